// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the boot-time memory loader.
package mem_loader_pkg;

  typedef enum logic [2:0] {
    StLenLo,
    StLenHi,
    StData,
    StWrite,
    StCsum,
    StDone,
    StError
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_CSUM    = 2'd3;

endpackage

// File: rtl/mem_loader_pack.sv
// Little-endian byte-to-word assembler; word_full flags the byte that completes a word.
module mem_loader_pack (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_full
);

  logic [1:0]  idx_q, idx_d;
  logic [23:0] shift_q, shift_d;

  always_comb begin
    idx_d   = idx_q;
    shift_d = shift_q;
    if (clear) begin
      idx_d   = 2'd0;
      shift_d = 24'd0;
    end else if (byte_valid) begin
      idx_d = idx_q + 2'd1;
      unique case (idx_q)
        2'd0:    shift_d[7:0]   = byte_data;
        2'd1:    shift_d[15:8]  = byte_data;
        2'd2:    shift_d[23:16] = byte_data;
        default: shift_d        = shift_q;
      endcase
    end
  end

  // The fourth byte bypasses the register so the word is complete in the same cycle.
  assign word      = {byte_data, shift_q};
  assign word_full = byte_valid && !clear && (idx_q == 2'd3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q   <= 2'd0;
      shift_q <= 24'd0;
    end else begin
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/mem_loader.sv
// Boot loader: framed byte stream -> 32-bit writes on the PicoRV32 native bus, then
// XOR checksum check gating the CPU reset.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        clear,
  output logic        mem_valid,
  output logic        mem_instr,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic        cpu_resetn,
  output logic [15:0] words_written
);

  localparam logic [16:0] MaxWords = 17'(MAX_WORDS);
  localparam logic [7:0]  TmoLast  = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] words_q, words_d;
  logic [7:0]  csum_q, csum_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [31:0] wdata_q, wdata_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [1:0]  err_q, err_d;

  logic        accept;
  logic        pack_valid;
  logic        pack_clear;
  logic [31:0] pack_word;
  logic        word_full;
  logic [15:0] len_full;
  logic [15:0] words_inc;

  assign in_ready   = (state_q == StLenLo) || (state_q == StLenHi) ||
                      (state_q == StData)  || (state_q == StCsum);
  assign accept     = in_valid && in_ready;
  assign pack_valid = accept && (state_q == StData);
  assign pack_clear = (state_q == StLenLo);
  assign len_full   = {in_data, len_q[7:0]};
  assign words_inc  = words_q + 16'd1;

  mem_loader_pack u_pack (
    .clk        (clk),
    .reset      (reset),
    .clear      (pack_clear),
    .byte_valid (pack_valid),
    .byte_data  (in_data),
    .word       (pack_word),
    .word_full  (word_full)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    words_d = words_q;
    csum_d  = csum_q;
    tmo_d   = tmo_q;
    wdata_d = wdata_q;
    valid_d = valid_q;
    done_d  = done_q;
    error_d = error_q;
    err_d   = err_q;

    unique case (state_q)
      StLenLo: begin
        csum_d  = 8'd0;
        words_d = 16'd0;
        if (accept) begin
          len_d   = {8'd0, in_data};
          state_d = StLenHi;
        end
      end
      StLenHi: begin
        if (accept) begin
          len_d = len_full;
          if (len_full == 16'd0) begin
            state_d = StCsum;
          end else if ({1'b0, len_full} > MaxWords) begin
            state_d = StError;
            error_d = 1'b1;
            err_d   = ERR_LEN;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (accept) begin
          csum_d = csum_q ^ in_data;
          if (word_full) begin
            wdata_d = pack_word;
            valid_d = 1'b1;
            tmo_d   = 8'd0;
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        // A completion arriving on the last allowed cycle still counts.
        if (mem_ready) begin
          valid_d = 1'b0;
          words_d = words_inc;
          state_d = (words_inc == len_q) ? StCsum : StData;
        end else if (tmo_q == TmoLast) begin
          valid_d = 1'b0;
          state_d = StError;
          error_d = 1'b1;
          err_d   = ERR_TIMEOUT;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      StCsum: begin
        if (accept) begin
          if (in_data == csum_q) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d = StError;
            error_d = 1'b1;
            err_d   = ERR_CSUM;
          end
        end
      end
      StDone, StError: begin
        if (clear) begin
          state_d = StLenLo;
          done_d  = 1'b0;
          error_d = 1'b0;
          err_d   = ERR_NONE;
          words_d = 16'd0;
          csum_d  = 8'd0;
        end
      end
      default: state_d = StLenLo;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StLenLo;
      len_q   <= 16'd0;
      words_q <= 16'd0;
      csum_q  <= 8'd0;
      tmo_q   <= 8'd0;
      wdata_q <= 32'd0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      words_q <= words_d;
      csum_q  <= csum_d;
      tmo_q   <= tmo_d;
      wdata_q <= wdata_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      error_q <= error_d;
      err_q   <= err_d;
    end
  end

  // Address tracks the completed-write count, so it holds for the whole request.
  assign mem_addr      = BASE_ADDR + {14'd0, words_q, 2'b00};
  assign mem_valid     = valid_q;
  assign mem_instr     = 1'b0;
  assign mem_wdata     = wdata_q;
  assign mem_wstrb     = valid_q ? 4'hF : 4'h0;
  assign done          = done_q;
  assign error         = error_q;
  assign err_code      = err_q;
  assign cpu_resetn    = done_q;
  assign words_written = words_q;

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: frame table plus length, timeout and reset sequences.
module tb_mem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        clear;
  logic        mem_valid;
  logic        mem_instr;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        done;
  logic        error;
  logic [1:0]  err_code;
  logic        cpu_resetn;
  logic [15:0] words_written;

  mem_loader dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .clear         (clear),
    .mem_valid     (mem_valid),
    .mem_instr     (mem_instr),
    .mem_ready     (mem_ready),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .done          (done),
    .error         (error),
    .err_code      (err_code),
    .cpu_resetn    (cpu_resetn),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Responder: registered ready pulse after resp_delay extra cycles.
  logic resp_ready;
  logic spur;
  bit   resp_en;
  int   resp_delay;
  int   wait_cnt;
  assign mem_ready = resp_ready | spur;

  logic        held, unst, changed;
  logic [31:0] prev_addr, prev_wdata;
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  logic [3:0]  log_strb[$];
  logic        log_unst[$];
  assign changed = held && ((mem_addr != prev_addr) || (mem_wdata != prev_wdata));

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_ready <= 1'b0;
      wait_cnt   <= 0;
      held       <= 1'b0;
      unst       <= 1'b0;
      prev_addr  <= 32'd0;
      prev_wdata <= 32'd0;
    end else begin
      if (mem_valid && mem_ready) begin
        log_addr.push_back(mem_addr);
        log_data.push_back(mem_wdata);
        log_strb.push_back(mem_wstrb);
        log_unst.push_back(unst | changed);
        held <= 1'b0;
        unst <= 1'b0;
      end else if (mem_valid) begin
        held       <= 1'b1;
        unst       <= unst | changed;
        prev_addr  <= mem_addr;
        prev_wdata <= mem_wdata;
      end else begin
        held <= 1'b0;
        unst <= 1'b0;
      end
      if (!mem_valid || resp_ready) begin
        resp_ready <= 1'b0;
        wait_cnt   <= 0;
      end else if (resp_en) begin
        if (wait_cnt >= resp_delay) resp_ready <= 1'b1;
        else wait_cnt <= wait_cnt + 1;
      end
    end
  end

  typedef struct {
    logic [15:0] len;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [7:0]  csum;
    int          delay;
    bit          gaps;
    logic        exp_done;
    logic [1:0]  exp_err;
    logic [15:0] exp_words;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n = 0;
    if (gaps) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
    end
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 2000) begin
      tick();
      n++;
    end
    if (!in_ready) check("in_ready wait", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input vec_t v);
    logic [31:0] wd;
    send_byte(v.len[7:0], v.gaps);
    send_byte(v.len[15:8], v.gaps);
    for (int i = 0; i < int'(v.len) && i < 2; i++) begin
      wd = (i == 0) ? v.w0 : v.w1;
      for (int b = 0; b < 4; b++) send_byte(wd[8*b +: 8], v.gaps);
    end
    send_byte(v.csum, v.gaps);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear done", 32'(done), 32'd0);
    check("clear error", 32'(error), 32'd0);
    check("clear err_code", 32'(err_code), 32'd0);
    check("clear words", 32'(words_written), 32'd0);
    check("clear in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    log_addr.delete();
    log_data.delete();
    log_strb.delete();
    log_unst.delete();
    resp_delay = v.delay;
    send_frame(v);
    // Flags are registered off the checksum byte, so they are visible right here.
    check("done", 32'(done), 32'(v.exp_done));
    check("cpu_resetn", 32'(cpu_resetn), 32'(v.exp_done));
    check("error", 32'(error), 32'(v.exp_err != 2'd0));
    check("err_code", 32'(err_code), 32'(v.exp_err));
    check("words_written", 32'(words_written), 32'(v.exp_words));
    check("in_ready final", 32'(in_ready), 32'd0);
    check("write count", 32'(log_addr.size()), 32'(v.exp_words));
    for (int i = 0; i < log_addr.size() && i < 2; i++) begin
      check("wr addr", log_addr[i], 32'(4 * i));
      check("wr data", log_data[i], (i == 0) ? v.w0 : v.w1);
      check("wr strb", 32'(log_strb[i]), 32'hF);
      check("wr stable", 32'(log_unst[i]), 32'd0);
    end
    do_clear();
  endtask

  initial begin
    int cnt;
    reset = 1'b1; in_valid = 1'b0; in_data = 8'd0; clear = 1'b0;
    spur = 1'b0; resp_en = 1'b1; resp_delay = 0;

    vecs[0] = '{16'd2, 32'h4433_2211, 32'h8877_6655, 8'h88, 0, 1'b0, 1'b1, 2'd0, 16'd2};
    vecs[1] = '{16'd2, 32'h4433_2211, 32'h8877_6655, 8'h00, 0, 1'b0, 1'b0, 2'd3, 16'd2};
    vecs[2] = '{16'd0, 32'h0,         32'h0,         8'h00, 0, 1'b0, 1'b1, 2'd0, 16'd0};
    vecs[3] = '{16'd1, 32'hDEAD_BEEF, 32'h0,         8'h22, 5, 1'b1, 1'b1, 2'd0, 16'd1};
    vecs[4] = '{16'd2, 32'h0102_0304, 32'hA0B0_C0D0, 8'h04, 5, 1'b1, 1'b1, 2'd0, 16'd2};
    vecs[5] = '{16'd0, 32'h0,         32'h0,         8'h5A, 0, 1'b0, 1'b0, 2'd3, 16'd0};

    repeat (3) tick();
    check("rst mem_valid", 32'(mem_valid), 32'd0);
    check("rst mem_addr", mem_addr, 32'h0);
    check("rst mem_wdata", mem_wdata, 32'h0);
    check("rst mem_wstrb", 32'(mem_wstrb), 32'h0);
    check("rst mem_instr", 32'(mem_instr), 32'h0);
    check("rst done", 32'(done), 32'd0);
    check("rst cpu_resetn", 32'(cpu_resetn), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;
    tick();

    // Completion pulse with no request pending must not count.
    spur = 1'b1;
    tick();
    spur = 1'b0;
    tick();
    check("spurious ready", 32'(words_written), 32'd0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Oversized length: error immediately after LEN_HI, bus untouched.
    send_byte(8'h01, 1'b0);
    send_byte(8'h04, 1'b0);
    check("len error", 32'(error), 32'd1);
    check("len err_code", 32'(err_code), 32'd1);
    check("len in_ready", 32'(in_ready), 32'd0);
    repeat (3) tick();
    check("len no mem_valid", 32'(mem_valid), 32'd0);
    check("len cpu_resetn", 32'(cpu_resetn), 32'd0);
    do_clear();

    // Silent responder: request held for exactly TIMEOUT cycles.
    resp_en = 1'b0;
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int b = 0; b < 4; b++) send_byte(8'(b + 1), 1'b0);
    cnt = 0;
    while (mem_valid && cnt < 400) begin
      cnt++;
      tick();
    end
    check("timeout cycles", 32'(cnt), 32'd255);
    check("timeout error", 32'(error), 32'd1);
    check("timeout err_code", 32'(err_code), 32'd2);
    check("timeout words", 32'(words_written), 32'd0);
    do_clear();

    // Reset in the middle of an outstanding write.
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int b = 0; b < 4; b++) send_byte(8'hA0 + 8'(b), 1'b0);
    repeat (3) tick();
    check("pre-reset mem_valid", 32'(mem_valid), 32'd1);
    check("pre-reset wdata", mem_wdata, 32'hA3A2_A1A0);
    #2 reset = 1'b1;
    #1;
    check("async mem_valid", 32'(mem_valid), 32'd0);
    check("async mem_wdata", mem_wdata, 32'h0);
    check("async mem_wstrb", 32'(mem_wstrb), 32'h0);
    check("async words", 32'(words_written), 32'd0);
    check("async in_ready", 32'(in_ready), 32'd1);
    check("async cpu_resetn", 32'(cpu_resetn), 32'd0);
    tick();
    reset = 1'b0;
    resp_en = 1'b1;
    tick();
    run_vec(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
